// File: rtl/wb_stage_buffered.sv
// ---------------------------------------------------------------------------
// wb_stage_buffered
//
// Write-back stage with a pending-write queue. One of four result sources
// (ALU, memory read data, link address, immediate) is selected and, when the
// instruction writes the register file, the {dest, data} pair is queued.
// The queue head is presented to a back-pressured register-file write port.
// A combinational forwarding lookup lets earlier stages read results that
// are still waiting in the queue.
//
// Optional build macro:
//   WB_ZERO_REG_EN - register 0 is hard-wired to zero. Writes to register 0
//                    are dropped, and lookups of register 0 never hit.
//
// Parameters:
//   DATA_W  data path / register-file data width
//   ADDR_W  destination register address width
//   DEPTH   pending-write queue entries (>= 1, any integer)
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   flush                synchronous discard of all pending entries
//   in_valid / in_ready  upstream result handshake
//   regWrite             accepted result is to be written
//   wbSel                source select: 0 alu, 1 rdData, 2 linkAddr, 3 immVal
//   destReg              destination register
//   aluResult, rdData,
//   linkAddr, immVal     result sources
//   rf_we/addr/data      register-file write request (queue head)
//   rf_ready             register file accepts the write this cycle
//   q_addr               forwarding query register
//   q_hit / q_data       newest pending entry targeting q_addr
//   count                number of pending entries
// ---------------------------------------------------------------------------
module wb_stage_buffered #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         regWrite,
  input  logic [1:0]                   wbSel,
  input  logic [ADDR_W-1:0]            destReg,
  input  logic [DATA_W-1:0]            aluResult,
  input  logic [DATA_W-1:0]            rdData,
  input  logic [DATA_W-1:0]            linkAddr,
  input  logic [DATA_W-1:0]            immVal,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_addr,
  output logic [DATA_W-1:0]            rf_data,
  input  logic                         rf_ready,
  input  logic [ADDR_W-1:0]            q_addr,
  output logic                         q_hit,
  output logic [DATA_W-1:0]            q_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Queue storage. Payload is never reset; the per-entry valid bits and the
  // pointers/count decide what is visible.
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_nonempty;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_q_hit;
  logic [DATA_W-1:0] w_q_data;

  // Source select.
  function automatic logic [DATA_W-1:0] f_wb_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] rd,
    input logic [DATA_W-1:0] link,
    input logic [DATA_W-1:0] imm
  );
    logic [DATA_W-1:0] v;
    case (sel)
      2'd0:    v = alu;
      2'd1:    v = rd;
      2'd2:    v = link;
      default: v = imm;
    endcase
    return v;
  endfunction

  // Pointer advance with an explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_nonempty = (r_count != '0);

  // in_ready depends only on registered occupancy and flush: a pop in the
  // same cycle does not free a slot early, so rf_ready never reaches in_ready.
  assign w_in_ready = (r_count < FULL_CNT) && !flush;
  assign w_accept   = in_valid && w_in_ready;

`ifdef WB_ZERO_REG_EN
  assign w_push = w_accept && regWrite && (destReg != '0);
`else
  assign w_push = w_accept && regWrite;
`endif

  assign w_pop     = w_nonempty && rf_ready;
  assign w_wb_data = f_wb_mux(wbSel, aluResult, rdData, linkAddr, immVal);

  // Control state: pointers, occupancy and valid bits. Flush overrides both
  // push (already blocked through in_ready) and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= f_next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= f_next_ptr(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload write. A push never targets the head slot while it is being
  // popped: push needs a free slot, pop needs a non-empty queue, and the two
  // pointers only coincide when the queue is empty or full.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= destReg;
      r_data[r_wptr] <= w_wb_data;
    end
  end

  // Forwarding search, oldest to newest from the read pointer, so a later
  // match overrides an earlier one and the newest pending value wins.
  always_comb begin
    int               v_sum;
    logic [PTR_W-1:0] v_idx;
    w_q_hit  = 1'b0;
    w_q_data = '0;
    v_sum    = 0;
    v_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_sum = int'(r_rptr) + k;
      if (v_sum >= DEPTH) begin
        v_sum = v_sum - DEPTH;
      end
      v_idx = PTR_W'(v_sum);
      if (r_vld[v_idx] && (r_addr[v_idx] == q_addr)) begin
        w_q_hit  = 1'b1;
        w_q_data = r_data[v_idx];
      end
    end
`ifdef WB_ZERO_REG_EN
    if (q_addr == '0) begin
      w_q_hit  = 1'b0;
      w_q_data = '0;
    end
`endif
  end

  // Head presentation comes straight from storage; it is zeroed while empty
  // so idle and post-reset outputs are clean.
  assign rf_we    = w_nonempty;
  assign rf_addr  = w_nonempty ? r_addr[r_rptr] : '0;
  assign rf_data  = w_nonempty ? r_data[r_rptr] : '0;

  assign in_ready = w_in_ready;
  assign q_hit    = w_q_hit;
  assign q_data   = w_q_data;
  assign count    = r_count;

endmodule

// File: tb/tb_wb_stage_buffered.sv
module tb_wb_stage_buffered;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              regWrite;
  logic [1:0]        wbSel;
  logic [ADDR_W-1:0] destReg;
  logic [DATA_W-1:0] aluResult, rdData, linkAddr, immVal;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              rf_ready;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;
  logic [CNT_W-1:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t mq[$];

  wb_stage_buffered #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .regWrite(regWrite), .wbSel(wbSel), .destReg(destReg),
    .aluResult(aluResult), .rdData(rdData), .linkAddr(linkAddr), .immVal(immVal),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_ready(rf_ready),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] sel_src();
    case (wbSel)
      2'd0:    return aluResult;
      2'd1:    return rdData;
      2'd2:    return linkAddr;
      default: return immVal;
    endcase
  endfunction

  function automatic bit model_ready();
    return (mq.size() < DEPTH) && !flush;
  endfunction

  // Compare every DUT output with what the queue model says it must be.
  task automatic compare_model();
    int n;
    logic             e_hit;
    logic [DATA_W-1:0] e_q;
    n = mq.size();
    e_hit = 1'b0;
    e_q   = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (mq[i].a == q_addr) begin
        e_hit = 1'b1;
        e_q   = mq[i].d;
        break;
      end
    end
`ifdef WB_ZERO_REG_EN
    if (q_addr == '0) begin
      e_hit = 1'b0;
      e_q   = '0;
    end
`endif
    chk("in_ready", 32'(in_ready), 32'(model_ready()));
    chk("count",    32'(count),    32'(n));
    chk("rf_we",    32'(rf_we),    32'(n > 0));
    chk("rf_addr",  32'(rf_addr),  (n > 0) ? 32'(mq[0].a) : 32'd0);
    chk("rf_data",  32'(rf_data),  (n > 0) ? 32'(mq[0].d) : 32'd0);
    chk("q_hit",    32'(q_hit),    32'(e_hit));
    chk("q_data",   32'(q_data),   32'(e_q));
  endtask

  task automatic model_update();
    bit acc, pop, wr;
    if (flush) begin
      mq.delete();
    end else begin
      acc = in_valid && model_ready();
      pop = (mq.size() > 0) && rf_ready;
      wr  = acc && regWrite;
`ifdef WB_ZERO_REG_EN
      if (destReg == '0) wr = 1'b0;
`endif
      if (pop) void'(mq.pop_front());
      if (wr) mq.push_back({destReg, sel_src()});
    end
  endtask

  // Inputs are set at the falling edge; check, advance the model, clock.
  task automatic step();
    #1 compare_model();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; regWrite = 0; wbSel = 0; destReg = 0;
    aluResult = 0; rdData = 0; linkAddr = 0; immVal = 0;
  endtask

  task automatic offer(input logic [ADDR_W-1:0] rg, input logic [1:0] sel,
                       input logic [DATA_W-1:0] v);
    in_valid = 1; regWrite = 1; destReg = rg; wbSel = sel;
    aluResult = 16'h0011; rdData = 16'h0022; linkAddr = 16'h0033; immVal = 16'h0044;
    case (sel)
      2'd0: aluResult = v;
      2'd1: rdData    = v;
      2'd2: linkAddr  = v;
      default: immVal = v;
    endcase
    step();
  endtask

  initial begin
    rst = 1; rf_ready = 1; q_addr = 0;
    idle();
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_rf_we",    32'(rf_we),    32'd0);
    chk("rst_rf_addr",  32'(rf_addr),  32'd0);
    chk("rst_rf_data",  32'(rf_data),  32'd0);
    chk("rst_q_hit",    32'(q_hit),    32'd0);
    chk("rst_q_data",   32'(q_data),   32'd0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Single push, immediate drain.
    offer(3'd3, 2'd0, 16'h1234);
    idle();
    chk("t1_rf_we",   32'(rf_we),   32'd1);
    chk("t1_rf_addr", 32'(rf_addr), 32'd3);
    chk("t1_rf_data", 32'(rf_data), 32'h1234);
    step();
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_rf_we_off", 32'(rf_we), 32'd0);

    // Source select, held in the queue then drained in order.
    rf_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; regWrite = 1; destReg = ADDR_W'(i + 1); wbSel = 2'(i);
      aluResult = 16'h0011; rdData = 16'h0022; linkAddr = 16'h0033; immVal = 16'h0044;
      step();
    end
    idle();
    rf_ready = 1;
    begin
      logic [DATA_W-1:0] exp_seq [4];
      exp_seq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
      for (int i = 0; i < 4; i++) begin
        chk("sel_rf_data", 32'(rf_data), 32'(exp_seq[i]));
        chk("sel_rf_addr", 32'(rf_addr), 32'(i + 1));
        step();
      end
    end

    // Back-pressure: five offers, four accepted.
    rf_ready = 0;
    for (int i = 0; i < 5; i++) offer(ADDR_W'(i), 2'd3, DATA_W'(16'h0100 + i));
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    idle();
    rf_ready = 1;
    step();
    chk("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
    chk("bp_count_after_pop", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step();

    // Forwarding.
    rf_ready = 0;
    offer(3'd5, 2'd0, 16'h00AA);
    offer(3'd5, 2'd0, 16'h00BB);
    idle();
    q_addr = 3'd5;
    #1;
    chk("fwd_hit5",  32'(q_hit),  32'd1);
    chk("fwd_data5", 32'(q_data), 32'h00BB);
    q_addr = 3'd6;
    #1;
    chk("fwd_hit6",  32'(q_hit),  32'd0);
    chk("fwd_data6", 32'(q_data), 32'd0);
    @(negedge clk);
    rf_ready = 1;
    step(); step();

    // Flush with wrapped write pointer and a result offered in the flush cycle.
    rf_ready = 0;
    for (int i = 0; i < 3; i++) offer(ADDR_W'(i + 1), 2'd0, DATA_W'(16'h0200 + i));
    idle(); rf_ready = 1;
    step(); step();
    rf_ready = 0;
    for (int i = 0; i < 3; i++) offer(ADDR_W'(i + 4), 2'd1, DATA_W'(16'h0300 + i));
    chk("wrap_count", 32'(count), 32'd4);
    flush = 1; in_valid = 1; regWrite = 1; destReg = 3'd7; wbSel = 2'd3; immVal = 16'h0BAD;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    idle();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_rf_we", 32'(rf_we), 32'd0);
    step();

    // Register 0 handling.
    rf_ready = 0;
    offer(3'd0, 2'd3, 16'hFFFF);
    idle();
`ifdef WB_ZERO_REG_EN
    chk("zr_count", 32'(count), 32'd0);
    chk("zr_rf_we", 32'(rf_we), 32'd0);
`else
    chk("zr_rf_we",   32'(rf_we),   32'd1);
    chk("zr_rf_addr", 32'(rf_addr), 32'd0);
    chk("zr_rf_data", 32'(rf_data), 32'hFFFF);
`endif
    rf_ready = 1;
    step(); step();

    // Randomised traffic.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      regWrite  = ($urandom_range(0, 9) < 8);
      flush     = ($urandom_range(0, 99) < 3);
      rf_ready  = ($urandom_range(0, 1) == 1);
      wbSel     = 2'($urandom);
      destReg   = ADDR_W'($urandom);
      aluResult = DATA_W'($urandom);
      rdData    = DATA_W'($urandom);
      linkAddr  = DATA_W'($urandom);
      immVal    = DATA_W'($urandom);
      q_addr    = ADDR_W'($urandom);
      step();
    end

    // Asynchronous reset while entries are pending.
    idle(); rf_ready = 0;
    offer(3'd2, 2'd0, 16'h0A0A);
    offer(3'd3, 2'd0, 16'h0B0B);
    idle();
    #2 rst = 1;
    #1;
    chk("arst_rf_we",    32'(rf_we),    32'd0);
    chk("arst_count",    32'(count),    32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    mq.delete();
    @(negedge clk);
    rst = 0;
    rf_ready = 1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_stage_buffered.md
Name: wb_stage_buffered

Overview:
- Parametrised write-back stage that succeeds the single-mux write-back.
- Selects the result from one of four sources (ALU, memory read, link address, immediate) and queues register writes in a small FIFO.
- Drains the FIFO into a register-file write port that can be back-pressured.
- Exposes a forwarding lookup so earlier stages can read pending (not yet written) results.

Parameters:
- DATA_W, 16, width of data path and register-file data.
- ADDR_W, 3, width of destination register address.
- DEPTH, 4, pending-write FIFO entries; any integer >= 1, need not be a power of two.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous: discard all pending entries.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept a result this cycle.
- regWrite  in  1  result is to be written to the register file.
- wbSel  in  2  source select: 0 aluResult, 1 rdData, 2 linkAddr, 3 immVal.
- destReg  in  ADDR_W  destination register.
- aluResult  in  DATA_W  ALU result.
- rdData  in  DATA_W  memory read data.
- linkAddr  in  DATA_W  return address (PC+1).
- immVal  in  DATA_W  immediate (load-immediate).
- rf_we  out  1  register-file write request (head entry valid).
- rf_addr  out  ADDR_W  head entry destination.
- rf_data  out  DATA_W  head entry data.
- rf_ready  in  1  register file accepts the write this cycle.
- q_addr  in  ADDR_W  forwarding query register.
- q_hit  out  1  a pending entry targets q_addr.
- q_data  out  DATA_W  data of the newest matching pending entry.
- count  out  clog2(DEPTH+1)  number of pending entries.

Behaviour:
- Reset (async, rst=1): count=0, read/write pointers=0, all entry valid bits=0, rf_we=0, rf_addr=0, rf_data=0, q_hit=0, q_data=0, in_ready=1.
- Handshake:
  - in_ready = (count < DEPTH) and not flush. A full FIFO deasserts in_ready even if a pop occurs the same cycle (no combinational path from rf_ready to in_ready).
- Accept (in_valid and in_ready):
  - regWrite=1: push {destReg, mux(wbSel)} at the write pointer.
  - regWrite=0: the result is consumed and dropped; no entry, count unchanged.
- Drain: rf_we=1 whenever count>0; rf_addr/rf_data come from the head entry and are driven from registered storage only. When rf_we and rf_ready, pop the head.
- Latency: a result accepted in cycle N into an empty FIFO appears on rf_* in cycle N+1. Each entry is held stable on rf_* until popped.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: each pointer returns to 0 after reaching DEPTH-1 (explicit compare, not bit truncation).
- Forwarding: combinational search of all valid entries. q_hit=1 if any entry's addr equals q_addr; q_data is the most recently pushed match. With no match, q_hit=0 and q_data=0. The entry being pushed in the same cycle is not visible until the next cycle.
- Flush:
  - Takes priority over push and pop. Next cycle: count=0, pointers=0, rf_we=0.
  - A pop completing in the flush cycle is still counted as written by the register file; the FIFO clears regardless.
  - Any push offered in the flush cycle is not accepted (in_ready=0).
- Reset mid-drain: all pending entries are lost and rf_we drops immediately (async).

Optional Feature:
- Macro: WB_ZERO_REG_EN.
  - Defined: accepted results with destReg=0 are dropped as if regWrite=0 (register 0 hard-wired to zero), and q_addr=0 always gives q_hit=0, q_data=0.
  - Undefined: register 0 is treated like any other register.

Test Plan:
- Reset release, rf_ready=1: push regWrite=1, destReg=3, wbSel=0, aluResult=0x1234 -> next cycle rf_we=1, rf_addr=3, rf_data=0x1234; following cycle count=0, rf_we=0.
- Source select: four pushes to regs 1..4 with wbSel=0..3 and alu=0x0011, rd=0x0022, link=0x0033, imm=0x0044 -> rf_data sequence 0x0011, 0x0022, 0x0033, 0x0044 in order.
- Back-pressure, DEPTH=4, rf_ready=0: five results offered -> four accepted, in_ready=0 with count=4. Then rf_ready=1 -> entries drain in order; in_ready=1 the cycle after the first pop.
- Forwarding: pending reg5=0x00AA then reg5=0x00BB, rf_ready=0, q_addr=5 -> q_hit=1, q_data=0x00BB. With q_addr=6 -> q_hit=0, q_data=0.
- Flush and wrap: fill 3 entries, pop 2, push 3 (write pointer wraps), then assert flush with in_valid=1 -> next cycle count=0, rf_we=0, offered result not written.
- WB_ZERO_REG_EN defined: push destReg=0, data=0xFFFF -> count stays 0, rf_we stays 0. Undefined: the same push appears on rf_* with rf_addr=0.
